// File: rtl/coin_acceptor.sv
// coin_acceptor
// Measures the high time of a synchronised coin-slot sensor pulse and
// classifies the coin as a 5-unit coin, a 10-unit coin, a glitch or an invalid
// object. Accepted coins are queued in a small FIFO and delivered one per cycle
// to the vending FSM. Refused coins pulse the return gate and are counted.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   coin_sense   raw asynchronous sensor, high while a coin passes
//   enable       accept enable; low returns every coin
//   inhibit      stalls FIFO pops; pushes continue
//   coin         5 or 10 for one cycle per delivered coin, otherwise 0
//   coin_reject  one-cycle pulse driving the coin-return gate
//   fifo_full    FIFO holds DEPTH entries (registered)
//   rejected_cnt rejected coin count, saturating at 255
module coin_acceptor #(
    parameter int T5_MIN  = 8,
    parameter int T5_MAX  = 15,
    parameter int T10_MIN = 24,
    parameter int T10_MAX = 40,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_sense,
    input  logic       enable,
    input  logic       inhibit,
    output logic [4:0] coin,
    output logic       coin_reject,
    output logic       fifo_full,
    output logic [7:0] rejected_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [7:0]    T5_MIN_L  = 8'(T5_MIN);
    localparam logic [7:0]    T5_MAX_L  = 8'(T5_MAX);
    localparam logic [7:0]    T10_MIN_L = 8'(T10_MIN);
    localparam logic [7:0]    T10_MAX_L = 8'(T10_MAX);
    localparam logic [CW-1:0] DEPTH_L   = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_L    = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ARM      = 2'd0,
        IDLE     = 2'd1,
        MEASURE  = 2'd2,
        OVERLONG = 2'd3
    } state_t;

    logic          sync1_r;
    logic          sync_r;
    logic [1:0]    prime_r;
    state_t        state_r;
    logic [7:0]    len_r;
    logic          fifo_mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic          valid_s;
    logic          ten_s;
    logic          invalid_s;
    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          reject_s;
    logic [CW-1:0] count_next_s;

    // Two-flop synchronizer plus a priming shift register. The priming bits
    // mark when both synchronizer flops hold real samples again after reset,
    // so ARM never mistakes the reset value of sync for a genuine low level
    // while a coin is still in the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync_r  <= 1'b0;
            prime_r <= 2'b00;
        end else begin
            sync1_r <= coin_sense;
            sync_r  <= sync1_r;
            prime_r <= {prime_r[0], 1'b1};
        end
    end

    // Classification of the finished pulse on the first low cycle of sync.
    always_comb begin
        valid_s   = 1'b0;
        ten_s     = 1'b0;
        invalid_s = 1'b0;
        case (state_r)
            MEASURE: begin
                if (!sync_r) begin
                    if (len_r < T5_MIN_L) begin
                        valid_s = 1'b0;            // glitch: silently ignored
                    end else if (len_r <= T5_MAX_L) begin
                        valid_s = 1'b1;
                    end else if (len_r >= T10_MIN_L) begin
                        valid_s = 1'b1;            // len_r never exceeds T10_MAX here
                        ten_s   = 1'b1;
                    end else begin
                        invalid_s = 1'b1;
                    end
                end else begin
                    valid_s = 1'b0;
                end
            end
            OVERLONG: begin
                if (!sync_r) begin
                    invalid_s = 1'b1;
                end else begin
                    invalid_s = 1'b0;
                end
            end
            default: begin
                valid_s = 1'b0;
            end
        endcase
    end

    // FIFO control: a pop frees a slot in the same cycle, so a full FIFO
    // still accepts a coin when it is also delivering one.
    always_comb begin
        empty_s      = (count_r == {CW{1'b0}});
        full_s       = (count_r == DEPTH_L);
        pop_s        = !empty_s && !inhibit;
        push_s       = valid_s && enable && (!full_s || pop_s);
        reject_s     = invalid_s || (valid_s && !push_s);
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_next_s = count_r - {{(CW-1){1'b0}}, 1'b1};
            default: count_next_s = count_r;
        endcase
    end

    // Pulse-length FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ARM;
            len_r   <= 8'd0;
        end else begin
            case (state_r)
                ARM: begin
                    len_r <= 8'd0;
                    if (prime_r[1] && !sync_r) begin
                        state_r <= IDLE;
                    end
                end
                IDLE: begin
                    if (sync_r) begin
                        state_r <= MEASURE;
                        len_r   <= 8'd1;
                    end
                end
                MEASURE: begin
                    if (sync_r) begin
                        if (len_r == T10_MAX_L) begin
                            state_r <= OVERLONG;
                        end else begin
                            len_r <= len_r + 8'd1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                OVERLONG: begin
                    if (!sync_r) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= ARM;
                    len_r   <= 8'd0;
                end
            endcase
        end
    end

    // FIFO storage; each entry is one bit: 1 = 10-unit coin, 0 = 5-unit coin.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= ten_s;
        end
    end

    // FIFO pointers, occupancy and the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            coin         <= 5'd0;
            coin_reject  <= 1'b0;
            fifo_full    <= 1'b0;
            rejected_cnt <= 8'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= (wr_ptr_r == LAST_L) ? {PW{1'b0}} : wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == LAST_L) ? {PW{1'b0}} : rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
                coin     <= fifo_mem_r[rd_ptr_r] ? 5'd10 : 5'd5;
            end else begin
                coin <= 5'd0;
            end
            count_r     <= count_next_s;
            fifo_full   <= (count_next_s == DEPTH_L);
            coin_reject <= reject_s;
            if (reject_s && (rejected_cnt != 8'hFF)) begin
                rejected_cnt <= rejected_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor
// Directed self-checking bench for coin_acceptor with default parameters.
// A negedge monitor logs every delivered coin and every coin_reject cycle;
// sections compare deltas of those logs and direct samples against
// hand-computed values.
module tb_coin_acceptor;

    logic       clk;
    logic       rst;
    logic       coin_sense;
    logic       enable;
    logic       inhibit;
    logic [4:0] coin;
    logic       coin_reject;
    logic       fifo_full;
    logic [7:0] rejected_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    int coin_q[$];
    int rej_cycles = 0;

    coin_acceptor dut (
        .clk          (clk),
        .rst          (rst),
        .coin_sense   (coin_sense),
        .enable       (enable),
        .inhibit      (inhibit),
        .coin         (coin),
        .coin_reject  (coin_reject),
        .fifo_full    (fifo_full),
        .rejected_cnt (rejected_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (coin != 5'd0) coin_q.push_back(int'(coin));
        if (coin_reject) rej_cycles = rej_cycles + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts and ends on a falling edge; sense is high for n full cycles.
    task automatic pulse(input int n);
        coin_sense = 1'b1;
        repeat (n) @(negedge clk);
        coin_sense = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int q0;
    int r0;
    int lens [8] = '{7, 8, 15, 16, 23, 24, 40, 41};
    int outv [8] = '{0, 5, 5, -1, -1, 10, 10, -1};
    int seq  [5] = '{5, 10, 10, 5, 10};

    initial begin
        rst        = 1'b1;
        coin_sense = 1'b0;
        enable     = 1'b1;
        inhibit    = 1'b0;
        idle(3);
        check_eq("rst_coin", int'(coin), 0);
        check_eq("rst_reject", int'(coin_reject), 0);
        check_eq("rst_full", int'(fifo_full), 0);
        check_eq("rst_cnt", int'(rejected_cnt), 0);
        rst = 1'b0;
        idle(5);

        // 10-cycle pulse: coin=5 exactly after the 4th edge sampling sense low.
        q0 = coin_q.size(); r0 = rej_cycles;
        pulse(10);
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            check_eq($sformatf("lat_edge%0d", e), int'(coin), (e == 4) ? 5 : 0);
        end
        idle(5);
        check_eq("lat_ncoins", coin_q.size() - q0, 1);
        check_eq("lat_rej", rej_cycles - r0, 0);

        // 30, 3, 20 cycle pulses: one 10, one glitch, one reject.
        q0 = coin_q.size(); r0 = rej_cycles;
        pulse(30); idle(6);
        pulse(3);  idle(6);
        pulse(20); idle(8);
        check_eq("mix_ncoins", coin_q.size() - q0, 1);
        if (coin_q.size() > q0) check_eq("mix_val", coin_q[q0], 10);
        check_eq("mix_rej", rej_cycles - r0, 1);
        check_eq("mix_cnt", int'(rejected_cnt), 1);

        // Overlong pulse, then a valid coin with enable low.
        q0 = coin_q.size(); r0 = rej_cycles;
        pulse(60); idle(8);
        check_eq("long_ncoins", coin_q.size() - q0, 0);
        check_eq("long_rej", rej_cycles - r0, 1);
        enable = 1'b0;
        pulse(10); idle(8);
        enable = 1'b1;
        check_eq("dis_ncoins", coin_q.size() - q0, 0);
        check_eq("dis_rej", rej_cycles - r0, 2);
        check_eq("dis_cnt", int'(rejected_cnt), 3);

        // Fill the FIFO under inhibit; the 5th coin is refused.
        q0 = coin_q.size(); r0 = rej_cycles;
        inhibit = 1'b1;
        pulse(10); idle(6);
        pulse(30); idle(6);
        pulse(30); idle(6);
        check_eq("fill3_full", int'(fifo_full), 0);
        pulse(10); idle(6);
        check_eq("fill4_full", int'(fifo_full), 1);
        pulse(10); idle(6);
        check_eq("fill5_rej", rej_cycles - r0, 1);
        check_eq("fill5_cnt", int'(rejected_cnt), 4);
        check_eq("fill_nopop", coin_q.size() - q0, 0);

        // Push and pop together while full: release inhibit in the
        // classification cycle of one more 10-unit coin.
        r0 = rej_cycles;
        pulse(30);
        idle(2);
        inhibit = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq($sformatf("drain%0d", k), int'(coin), seq[k]);
            if (k == 0) check_eq("drain_full_kept", int'(fifo_full), 1);
        end
        @(negedge clk);
        check_eq("drain_end", int'(coin), 0);
        check_eq("drain_empty_full", int'(fifo_full), 0);
        check_eq("drain_rej", rej_cycles - r0, 0);

        // Classification boundaries.
        for (int i = 0; i < 8; i++) begin
            q0 = coin_q.size(); r0 = rej_cycles;
            pulse(lens[i]); idle(8);
            check_eq($sformatf("len%0d_ncoins", lens[i]), coin_q.size() - q0, (outv[i] > 0) ? 1 : 0);
            if (outv[i] > 0 && coin_q.size() > q0)
                check_eq($sformatf("len%0d_val", lens[i]), coin_q[q0], outv[i]);
            check_eq($sformatf("len%0d_rej", lens[i]), rej_cycles - r0, (outv[i] < 0) ? 1 : 0);
        end

        // Reset mid-pulse with the coin still in the slot.
        q0 = coin_q.size(); r0 = rej_cycles;
        coin_sense = 1'b1;
        idle(14);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(10);
        coin_sense = 1'b0;
        idle(10);
        check_eq("rstmid_ncoins", coin_q.size() - q0, 0);
        check_eq("rstmid_rej", rej_cycles - r0, 0);
        check_eq("rstmid_cnt", int'(rejected_cnt), 0);
        pulse(10); idle(8);
        check_eq("rstmid_next_ncoins", coin_q.size() - q0, 1);
        if (coin_q.size() > q0) check_eq("rstmid_next_val", coin_q[q0], 5);

        // Saturation of the reject counter.
        for (int i = 0; i < 254; i++) begin
            pulse(50); idle(3);
        end
        idle(3);
        check_eq("sat_254", int'(rejected_cnt), 254);
        for (int i = 0; i < 46; i++) begin
            pulse(50); idle(3);
        end
        idle(3);
        check_eq("sat_255", int'(rejected_cnt), 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 SHALL have parameter T5_MIN, default 8: minimum high-time, in cycles, of a 5-unit coin pulse.
REQ-002 SHALL have parameter T5_MAX, default 15: maximum high-time, in cycles, of a 5-unit coin pulse.
REQ-003 SHALL have parameter T10_MIN, default 24: minimum high-time, in cycles, of a 10-unit coin pulse.
REQ-004 SHALL have parameter T10_MAX, default 40 (≤254): maximum high-time, in cycles, of a 10-unit coin pulse.
REQ-005 SHALL have parameter DEPTH, default 4: accepted-coin FIFO depth.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 coin_sense  input  1  raw asynchronous coin-slot sensor; high while a coin passes.
REQ-009 enable  input  1  accept enable; low means every coin is returned.
REQ-010 inhibit  input  1  high stalls FIFO pops; the FIFO keeps accumulating.
REQ-011 coin  output  5  accepted coin value to the vending FSM: 5 or 10 for exactly one cycle per coin, otherwise 0.
REQ-012 coin_reject  output  1  one-cycle pulse; drives the coin-return gate.
REQ-013 fifo_full  output  1  FIFO holds DEPTH entries.
REQ-014 rejected_cnt  output  8  count of rejected coins, saturating at 255.

Function
REQ-015 coin_sense SHALL pass through a 2-flop synchronizer; "sync" means the second-flop output; all decisions use sync only.
REQ-016 The FSM SHALL have states ARM, IDLE, MEASURE and OVERLONG.
REQ-017 ARM SHALL go to IDLE on the first cycle sync is low.
REQ-018 IDLE SHALL go to MEASURE when sync is high, loading the 8-bit length counter L=1.
REQ-019 In MEASURE, L SHALL increment while sync is high; when L would exceed T10_MAX, the FSM SHALL go to OVERLONG.
REQ-020 On the first cycle sync is low in MEASURE, the block SHALL classify L and go to IDLE:
- L<T5_MIN: glitch; ignore, no reject.
- T5_MIN..T5_MAX: value 5.
- T10_MIN..T10_MAX: value 10.
- Any other L: invalid.
REQ-021 OVERLONG SHALL wait for sync low, then classify as invalid and go to IDLE.
REQ-022 An invalid result SHALL be a reject.
REQ-023 A valid result SHALL be a reject when enable is low in the classification cycle.
REQ-024 A valid result SHALL be a reject when the FIFO is full and no pop occurs in the same cycle.
REQ-025 Otherwise a valid result SHALL be pushed at the end of the classification cycle.
REQ-026 A reject SHALL assert coin_reject for exactly the cycle after classification and increment rejected_cnt (saturating at 255).
REQ-027 Each cycle with FIFO non-empty and inhibit low, the block SHALL pop the head into the coin register (coin valid next cycle); otherwise coin register = 0.
REQ-028 Push and pop in the same cycle SHALL both take effect, leaving count unchanged; this applies with the FIFO full.
REQ-029 Accepted coins SHALL leave in arrival order, at most one per cycle, back-to-back allowed.
REQ-030 Latency: with FIFO empty and inhibit low, coin SHALL be valid in the cycle after the 4th rising edge sampling coin_sense low, counting the first such edge as 1.
REQ-031 fifo_full SHALL be registered: it reflects the count after each edge.

Reset
REQ-032 rst SHALL set sync flops=0, state=ARM, L=0, FIFO empty, coin=0, coin_reject=0, fifo_full=0, rejected_cnt=0.
REQ-033 rst during MEASURE or OVERLONG SHALL discard the in-flight coin with no reject.
REQ-034 After rst, if coin_sense is still high, the block SHALL remain in ARM and ignore that pulse entirely.

Verification
REQ-035 enable=1, inhibit=0, 10-cycle pulse -> a single coin=5 cycle at REQ-030 latency; coin_reject never high.
REQ-036 30-cycle pulse, then 3-cycle pulse, then 20-cycle pulse -> coin=10; then nothing; then coin_reject=1 for 1 cycle, rejected_cnt=1.
REQ-037 Held-high 60-cycle pulse -> no coin, one coin_reject after the fall; enable=0 with 10-cycle pulse -> reject, no coin.
REQ-038 inhibit=1, five 10-cycle pulses -> fifo_full after 4; 5th rejected; release inhibit -> coin=5 on 4 consecutive cycles, then 0.
REQ-039 rst asserted at L=12 mid-pulse, coin_sense held high 10 more cycles -> no coin, no reject; a following 10-cycle pulse -> coin=5.
REQ-040 300 consecutive 3-cycle-gap 50-cycle pulses -> rejected_cnt saturates at 255.
